branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-002 SHALL have parameter CC_RESET, default 3'b100, CC value after reset (ZF=1, SF=0, OF=0).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 e_valid  input  1  E stage holds a real instruction (not a bubble).
REQ-006 e_icode  input  4  E-stage icode (2=cmovXX, 6=OPq, 7=jXX).
REQ-007 e_ifun  input  4  E-stage ifun (condition code selector).
REQ-008 alu_flags  input  3  ALU result flags {zf,sf,of} for the E-stage OPq.
REQ-009 exc_mw  input  1  exception status present in M or W stage; blocks CC update.
REQ-010 halt_w  input  1  non-AOK status reached W; processor stops.
REQ-011 cc  output  3  architectural condition codes {zf,sf,of}.
REQ-012 cnd  output  1  condition result for E-stage cmovXX/jXX.
REQ-013 mispredict  output  1  E-stage jXX predicted taken but not taken.
REQ-014 squash  output  1  registered one-cycle pulse: bubble D and E.
REQ-015 halted  output  1  block in HALTED state.
REQ-016 br_count  output  CNT_W  jXX instructions resolved.
REQ-017 mis_count  output  CNT_W  mispredicted jXX instructions.

Function
REQ-018 cnd SHALL be combinational from current cc and e_ifun: 0 always; 1 le=(sf^of)|zf; 2 l=sf^of; 3 e=zf; 4 ne=~zf; 5 ge=~(sf^of); 6 g=~(sf^of)&~zf; ifun 7..15 -> 0.
REQ-019 cnd SHALL be forced 0 when e_valid=0, state!=RUN, or e_icode not in {2,7}.
REQ-020 FSM states SHALL be RUN, FLUSH, HALTED.
REQ-021 RUN->FLUSH when mispredict=1; FLUSH->RUN after exactly one cycle; any state->HALTED when halt_w=1 (priority over all other transitions); HALTED exits only via reset.
REQ-022 mispredict SHALL = (state==RUN) & e_valid & e_icode==7 & ~cnd, combinational, zero latency.
REQ-023 squash SHALL be 1 exactly in FLUSH state (one cycle after mispredict), 0 otherwise.
REQ-024 In FLUSH, E-stage inputs SHALL be ignored: no CC update, no counter update, mispredict=0.
REQ-025 cc SHALL load alu_flags on the edge where state==RUN & e_valid & e_icode==6 & ~exc_mw & ~halt_w; otherwise hold.
REQ-026 cnd for an instruction SHALL use cc before any update on the same edge (OPq directly followed by jXX sees OPq flags on the next cycle).
REQ-027 br_count SHALL increment on each edge with state==RUN & e_valid & e_icode==7 & ~halt_w; mis_count additionally requires mispredict.
REQ-028 Counters SHALL saturate at all-ones, never wrap.
REQ-029 In HALTED, cc, counters frozen; cnd, mispredict, squash = 0; halted=1.

Reset
REQ-030 On rst=1, immediately and regardless of clock: state=RUN, cc=CC_RESET, counters=0, squash=0, halted=0.
REQ-031 Reset asserted mid-FLUSH SHALL cancel the pending squash pulse.
REQ-032 First edge after rst deassert SHALL operate normally in RUN.

Structure
REQ-033 Shared package y86_pkg SHALL hold icode constants (ICMOV=2, IOPQ=6, IJXX=7), ifun condition constants (0..6) and the FSM state enum.
REQ-034 Condition evaluation SHALL be one sub-module, cc_eval (inputs ifun, cc; output cnd), instantiated once.
REQ-035 Block SHALL contain no other sub-modules; counters and FSM inline.

Verification
REQ-036 Reset, then OPq with alu_flags=3'b010, then jXX ifun=2 (l) -> cc=3'b010, cnd=1, mispredict=0, br_count=1, mis_count=0.
REQ-037 cc=3'b100, jXX ifun=4 (ne) -> mispredict=1 same cycle, squash=1 next cycle only, mis_count=1; E inputs during FLUSH have no effect.
REQ-038 OPq with exc_mw=1 and alu_flags=3'b001 -> cc unchanged at 3'b100.
REQ-039 halt_w=1 coincident with mispredicting jXX -> HALTED next cycle, squash=0, counters unchanged, cc frozen through further OPq stimulus until rst.
REQ-040 CNT_W=4, 20 mispredicting jXX -> br_count and mis_count hold 4'hF.
REQ-041 All ifun 0..15 against all 8 cc values with cmovXX -> cnd matches REQ-018 table; rst asserted between clock edges clears state asynchronously.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, branch/cmov condition selectors
// and the branch-control FSM state type.
package y86_pkg;

  localparam logic [3:0] ICMOV = 4'd2;
  localparam logic [3:0] IOPQ  = 4'd6;
  localparam logic [3:0] IJXX  = 4'd7;

  localparam logic [3:0] C_YES = 4'd0;
  localparam logic [3:0] C_LE  = 4'd1;
  localparam logic [3:0] C_L   = 4'd2;
  localparam logic [3:0] C_E   = 4'd3;
  localparam logic [3:0] C_NE  = 4'd4;
  localparam logic [3:0] C_GE  = 4'd5;
  localparam logic [3:0] C_G   = 4'd6;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FLUSH   = 2'd1,
    ST_HALTED  = 2'd2
  } state_e;

endpackage

// File: rtl/branch_ctrl_cc_eval.sv
// Condition evaluator: decodes a cmovXX/jXX ifun against {zf,sf,of}.
module cc_eval
  import y86_pkg::*;
(
  input  logic [3:0] ifun,
  input  logic [2:0] cc,
  output logic       cnd
);

  logic zf, sf, of;
  assign zf = cc[2];
  assign sf = cc[1];
  assign of = cc[0];

  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
    cnd = 1'b0;
    unique case (ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (sf ^ of) | zf;
      C_L:     cnd = sf ^ of;
      C_E:     cnd = zf;
      C_NE:    cnd = ~zf;
      C_GE:    cnd = ~(sf ^ of);
      C_G:     cnd = ~(sf ^ of) & ~zf;
      default: cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch control: condition codes, jXX resolution and mispredict squash,
// halt handling and saturating branch statistics.
module branch_ctrl
  import y86_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [2:0]  CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             e_valid,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [2:0]       alu_flags,
  input  logic             exc_mw,
  input  logic             halt_w,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             mispredict,
  output logic             squash,
  output logic             halted,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  state_e            state_q, state_d;
  logic [2:0]        cc_q, cc_d;
  logic [CNT_W-1:0]  br_q, br_d;
  logic [CNT_W-1:0]  mis_q, mis_d;
  logic              cnd_raw;
  logic              e_active, is_br;

  cc_eval u_cc_eval (
    .ifun (e_ifun),
    .cc   (cc_q),
    .cnd  (cnd_raw)
  );

  // Only a real instruction in RUN may resolve conditions or touch state.
  assign e_active   = (state_q == ST_RUN) & e_valid;
  assign is_br      = e_active & (e_icode == IJXX);
  assign cnd        = e_active & ((e_icode == ICMOV) | (e_icode == IJXX)) & cnd_raw;
  assign mispredict = is_br & ~cnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      // NOTE: non-blocking assignment so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_w) begin
      state_d = ST_HALTED;
    end else begin
      unique case (state_q)
        ST_RUN:    if (mispredict) state_d = ST_FLUSH;
        ST_FLUSH:  state_d = ST_RUN;
        ST_HALTED: state_d = ST_HALTED;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    squash = (state_q == ST_FLUSH);
    halted = (state_q == ST_HALTED);
  end

  always_comb begin
    cc_d  = cc_q;
    br_d  = br_q;
    mis_d = mis_q;
    if (e_active && (e_icode == IOPQ) && !exc_mw && !halt_w) begin
      cc_d = alu_flags;
    end
    // Counters stick at all-ones rather than wrapping.
    if (is_br && !halt_w) begin
      if (br_q != '1) br_d = br_q + CNT_W'(1);
      if (mispredict && (mis_q != '1)) mis_d = mis_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q  <= CC_RESET;
      br_q  <= '0;
      mis_q <= '0;
    end else begin
      cc_q  <= cc_d;
      br_q  <= br_d;
      mis_q <= mis_d;
    end
  end

  assign cc        = cc_q;
  assign br_count  = br_q;
  assign mis_count = mis_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus random
// traffic against a behavioural model; default and 4-bit counter instances.
module tb_branch_ctrl;
  import y86_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       e_valid;
  logic [3:0] e_icode;
  logic [3:0] e_ifun;
  logic [2:0] alu_flags;
  logic       exc_mw;
  logic       halt_w;

  logic [2:0]  cc_w, cc_n;
  logic        cnd_w, cnd_n, mis_w, mis_n, sq_w, sq_n, hl_w, hl_n;
  logic [15:0] br_w, mc_w;
  logic [3:0]  br_n, mc_n;

  int checks   = 0;
  int failures = 0;

  // Behavioural model
  logic [2:0] m_cc;
  bit         m_flush, m_halt;
  int         m_br, m_mc;

  always #5 clk = ~clk;

  branch_ctrl dut_w (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_flags(alu_flags), .exc_mw(exc_mw), .halt_w(halt_w),
    .cc(cc_w), .cnd(cnd_w), .mispredict(mis_w), .squash(sq_w), .halted(hl_w),
    .br_count(br_w), .mis_count(mc_w)
  );

  branch_ctrl #(.CNT_W(4)) dut_n (
    .clk(clk), .rst(rst), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .alu_flags(alu_flags), .exc_mw(exc_mw), .halt_w(halt_w),
    .cc(cc_n), .cnd(cnd_n), .mispredict(mis_n), .squash(sq_n), .halted(hl_n),
    .br_count(br_n), .mis_count(mc_n)
  );

  function automatic bit ref_cond(input int f, input logic [2:0] c);
    bit zf, sf, of;
    zf = c[2]; sf = c[1]; of = c[0];
    case (f)
      0: return 1'b1;
      1: return (sf != of) || zf;
      2: return sf != of;
      3: return zf;
      4: return !zf;
      5: return sf == of;
      6: return (sf == of) && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("cc_w",     32'(cc_w), 32'(m_cc));
    check("cc_n",     32'(cc_n), 32'(m_cc));
    check("squash_w", 32'(sq_w), 32'(m_flush));
    check("squash_n", 32'(sq_n), 32'(m_flush));
    check("halted_w", 32'(hl_w), 32'(m_halt));
    check("halted_n", 32'(hl_n), 32'(m_halt));
    check("br_w",     32'(br_w), 32'(sat(m_br, 65535)));
    check("mc_w",     32'(mc_w), 32'(sat(m_mc, 65535)));
    check("br_n",     32'(br_n), 32'(sat(m_br, 15)));
    check("mc_n",     32'(mc_n), 32'(sat(m_mc, 15)));
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without an edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_cc = 3'b100; m_flush = 0; m_halt = 0; m_br = 0; m_mc = 0;
    check_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One instruction slot: drive, check combinational outputs, clock, check state.
  task automatic step(input bit v, input int ic, input int f, input logic [2:0] fl,
                      input bit ex, input bit h);
    bit run, ecnd, emis;
    e_valid = v; e_icode = 4'(ic); e_ifun = 4'(f); alu_flags = fl; exc_mw = ex; halt_w = h;
    #1;
    run  = !m_halt && !m_flush;
    ecnd = run && v && (ic == 2 || ic == 7) && ref_cond(f, m_cc);
    emis = run && v && ic == 7 && !ecnd;
    check("cnd_w", 32'(cnd_w), 32'(ecnd));
    check("cnd_n", 32'(cnd_n), 32'(ecnd));
    check("mis_w", 32'(mis_w), 32'(emis));
    check("mis_n", 32'(mis_n), 32'(emis));
    @(posedge clk);
    if (run && v && ic == 6 && !ex && !h) m_cc = fl;
    if (run && v && ic == 7 && !h) begin
      m_br++;
      if (emis) m_mc++;
    end
    if (h)            begin m_halt = 1; m_flush = 0; end
    else if (m_flush) m_flush = 0;
    else if (emis)    m_flush = 1;
    #1;
    check_state();
  endtask

  initial begin
    rst = 1'b0; e_valid = 0; e_icode = 0; e_ifun = 0; alu_flags = 0; exc_mw = 0; halt_w = 0;
    #2;
    do_reset();

    // OPq then jl sees the freshly loaded flags
    step(1, 6, 0, 3'b010, 0, 0);
    check("opq_cc", 32'(cc_w), 32'h2);
    step(1, 7, 2, 3'b000, 0, 0);
    check("jl_br", 32'(br_w), 32'd1);
    check("jl_mc", 32'(mc_w), 32'd0);

    // jne with zf=1 mispredicts; FLUSH ignores E-stage inputs
    do_reset();
    step(1, 7, 4, 3'b000, 0, 0);
    check("jne_squash", 32'(sq_w), 32'd1);
    check("jne_mc", 32'(mc_w), 32'd1);
    step(1, 6, 0, 3'b001, 0, 0);
    check("flush_end", 32'(sq_w), 32'd0);
    check("flush_cc", 32'(cc_w), 32'h4);

    // Exception in M/W blocks the CC write
    step(1, 6, 0, 3'b001, 1, 0);
    check("exc_cc", 32'(cc_w), 32'h4);

    // Halt coincident with a mispredicting jXX
    step(1, 7, 4, 3'b000, 0, 1);
    check("halt_sq", 32'(sq_w), 32'd0);
    check("halt_mc", 32'(mc_w), 32'd1);
    repeat (3) step(1, 6, 0, 3'b011, 0, 0);
    check("halt_cc", 32'(cc_w), 32'h4);

    // Reset arriving mid-FLUSH cancels the squash pulse
    do_reset();
    step(1, 7, 9, 3'b000, 0, 0);
    do_reset();
    step(1, 7, 0, 3'b000, 0, 0);

    // Full condition table through cmovXX
    for (int c = 0; c < 8; c++) begin
      step(1, 6, 0, 3'(c), 0, 0);
      for (int f = 0; f < 16; f++) step(1, 2, f, 3'($urandom_range(0, 7)), 0, 0);
    end

    // Saturation of the 4-bit instance after 20 mispredicts
    do_reset();
    repeat (40) step(1, 7, 7, 3'b000, 0, 0);
    check("sat_br_n", 32'(br_n), 32'hF);
    check("sat_mc_n", 32'(mc_n), 32'hF);
    check("sat_br_w", 32'(br_w), 32'd20);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        int sel, ic;
        sel = int'($urandom_range(0, 5));
        case (sel)
          0: ic = 2;
          1: ic = 6;
          2, 3: ic = 7;
          default: ic = int'($urandom_range(0, 15));
        endcase
        step($urandom_range(0, 99) < 85, ic, int'($urandom_range(0, 15)),
             3'($urandom_range(0, 7)), $urandom_range(0, 99) < 15,
             $urandom_range(0, 199) < 2);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
